// File: rtl/wb_key_poller.sv
// wb_key_poller: read-only Wishbone initiator that polls a keypad responder and
// queues every new key press into a small FIFO drained through a valid/ready port.
module wb_key_poller #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter logic [15:0] POLL_DIV   = 16'd50000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [4:0]  fifo_count,
  output logic        overflow,
  output logic        bus_err,
  input  logic        err_clr
);
  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_STAT = 2'd1;
  localparam logic [1:0] RD_CODE = 2'd2;
  localparam logic [1:0] PUSH    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    wait_q, wait_d;
  logic          cyc_q, cyc_d;
  logic          prev_q, prev_d;
  logic [3:0]    code_q, code_d;
  logic          ovf_q, ovf_d;
  logic          berr_q, berr_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic          push, push_ok, pop, berr_set, timed_out;
  logic          unused_dat;

  assign unused_dat = ^wb_dat_i[31:4];

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hF;
  assign wb_dat_o   = 32'd0;
  assign wb_adr_o   = (state_q == RD_CODE) ? BASE_ADR : BASE_ADR + 32'd4;

  assign key_valid  = (cnt_q != 5'd0);
  assign key_code   = key_valid ? mem_q[rd_q] : 4'h0;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign bus_err    = berr_q;

  assign timed_out  = (wait_q == TIMEOUT - 8'd1);

  // Poll/fetch sequencer. RD_CODE spends its first cycle with cyc low so every
  // access is separated from the previous ack by at least one idle cycle.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wait_d   = wait_q;
    cyc_d    = cyc_q;
    prev_d   = prev_q;
    code_d   = code_q;
    berr_set = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (timer_q == POLL_DIV - 16'd1) begin
          state_d = RD_STAT;
          timer_d = 16'd0;
          cyc_d   = 1'b1;
          wait_d  = 8'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RD_STAT: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          prev_d  = wb_dat_i[0];
          state_d = (wb_dat_i[0] && !prev_q) ? RD_CODE : IDLE;
        end else if (timed_out) begin
          cyc_d    = 1'b0;
          berr_set = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RD_CODE: begin
        if (!cyc_q) begin
          cyc_d  = 1'b1;
          wait_d = 8'd0;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          code_d  = wb_dat_i[3:0];
          state_d = PUSH;
        end else if (timed_out) begin
          cyc_d    = 1'b0;
          berr_set = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        push    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // A push into a full FIFO still succeeds when the consumer pops in the same cycle.
  always_comb begin
    pop     = key_valid && key_ready;
    push_ok = push && ((cnt_q != DEPTH5) || pop);
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d  = (push && !push_ok) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    berr_d = berr_set ? 1'b1 : (err_clr ? 1'b0 : berr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= 16'd0;
      wait_q  <= 8'd0;
      cyc_q   <= 1'b0;
      prev_q  <= 1'b0;
      ovf_q   <= 1'b0;
      berr_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      berr_q  <= berr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    code_q <= code_d;
    if (push_ok) mem_q[wr_q] <= code_q;
  end

endmodule
